auto_scan_chip_sequencer: RTL and testbench

Campaign scheduler that runs the single Auto TA scan engine across the CHIP_NUM front-end chips on the DIF, one at a time. For each enabled chip it selects the chip, pulses the scan engine start, waits for finish or timeout, and brackets the engine's data with header and trailer words. All words go through one muxed write port to the scan FIFO. It sits between the control-register/USB command layer and the scan engine plus scan FIFO.

---
 rtl/auto_scan_chip_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_auto_scan_chip_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/auto_scan_chip_sequencer.sv
// Runs the scan engine over each enabled chip in turn and frames its data with header/trailer words.
// Header/trailer words are registered (1 cycle); passthrough adds 1 cycle; a full FIFO stalls header/trailer and drops passthrough.
module auto_scan_chip_sequencer #(
  parameter int CHIP_NUM    = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic                Clk_10MHz,
  input  logic                Rst_N,
  input  logic                In_Start,
  input  logic                In_Stop,
  input  logic [CHIP_NUM-1:0] In_Chip_Enable,
  input  logic                In_Scan_Finish,
  input  logic [15:0]         In_Scan_Fifo_Din,
  input  logic                In_Scan_Fifo_Wr,
  input  logic                In_Fifo_Full,
  output logic [CHIP_NUM-1:0] Out_Chip_Sel,
  output logic [3:0]          Out_Chip_ID,
  output logic                Out_Start_Scan,
  output logic [15:0]         Out_Fifo_Din,
  output logic                Out_Fifo_Wr,
  output logic                Out_Busy,
  output logic                Out_Done,
  output logic [CHIP_NUM-1:0] Out_Err_Chip,
  output logic                Out_Overflow
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_SELECT, ST_HEADER, ST_START, ST_WAIT,
    ST_DRAIN, ST_TRAILER, ST_NEXT, ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CHIP_NUM-1:0] en_q, en_d;
  logic [3:0]          idx_q, idx_d;
  logic [23:0]         cnt_q, cnt_d;
  logic [3:0]          status_q, status_d;
  logic                start_prev_q, start_prev_d;
  logic                fin_prev_q, fin_prev_d;
  logic [CHIP_NUM-1:0] sel_q, sel_d;
  logic [3:0]          id_q, id_d;
  logic                start_scan_q, start_scan_d;
  logic [15:0]         fifo_din_q, fifo_din_d;
  logic                fifo_wr_q, fifo_wr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CHIP_NUM-1:0] err_q, err_d;
  logic                ovf_q, ovf_d;

  logic                start_edge, fin_edge, found;
  logic [3:0]          pick;
  logic [CHIP_NUM-1:0] pick_oh;

  assign start_edge = In_Start & ~start_prev_q;
  assign fin_edge   = In_Scan_Finish & ~fin_prev_q;

  // Lowest enabled chip at or above the current index; descending loop keeps the last (lowest) match.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    pick_oh = '0;
    for (int i = CHIP_NUM - 1; i >= 0; i--) begin
      if (en_q[i] && (i >= int'(idx_q))) begin
        found      = 1'b1;
        pick       = 4'(i);
        pick_oh    = '0;
        pick_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    en_d         = en_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    status_d     = status_q;
    start_prev_d = In_Start;
    fin_prev_d   = In_Scan_Finish;
    sel_d        = sel_q;
    id_d         = id_q;
    start_scan_d = 1'b0;
    fifo_din_d   = fifo_din_q;
    fifo_wr_d    = 1'b0;
    done_d       = 1'b0;
    err_d        = err_q;
    ovf_d        = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          en_d    = In_Chip_Enable;
          err_d   = '0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (found) begin
          idx_d   = pick;
          id_d    = pick;
          sel_d   = pick_oh;
          cnt_d   = '0;
          state_d = ST_SELECT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_SELECT: begin
        if (In_Stop) state_d = ST_DONE;
        else if (cnt_q == 24'(SETTLE_CYC - 1)) state_d = ST_HEADER;
        else cnt_d = cnt_q + 24'd1;
      end
      ST_HEADER: begin
        if (In_Stop) begin
          state_d = ST_DONE;
        end else if (!In_Fifo_Full) begin
          fifo_wr_d    = 1'b1;
          fifo_din_d   = {8'hA5, 4'h0, idx_q};
          start_scan_d = 1'b1;
          state_d      = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        fifo_din_d = In_Scan_Fifo_Din;
        fifo_wr_d  = In_Scan_Fifo_Wr & ~In_Fifo_Full;
        if (In_Scan_Fifo_Wr && In_Fifo_Full) ovf_d = 1'b1;
        if (In_Stop) begin
          status_d = 4'hC;
          state_d  = ST_DRAIN;
        end else if (fin_edge) begin
          status_d = 4'h0;
          state_d  = ST_DRAIN;
        end else if (cnt_q == 24'(TIMEOUT_CYC - 1)) begin
          status_d = 4'hE;
          err_d    = err_q | sel_q;
          state_d  = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_DRAIN: state_d = ST_TRAILER;
      ST_TRAILER: begin
        if (!In_Fifo_Full) begin
          fifo_wr_d  = 1'b1;
          fifo_din_d = {8'h5A, status_q, idx_q};
          if (status_q == 4'hC) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_NEXT;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        sel_d   = '0;
        id_d    = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk_10MHz or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q      <= ST_IDLE;
      en_q         <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      status_q     <= '0;
      start_prev_q <= 1'b0;
      fin_prev_q   <= 1'b0;
      sel_q        <= '0;
      id_q         <= '0;
      start_scan_q <= 1'b0;
      fifo_din_q   <= '0;
      fifo_wr_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      status_q     <= status_d;
      start_prev_q <= start_prev_d;
      fin_prev_q   <= fin_prev_d;
      sel_q        <= sel_d;
      id_q         <= id_d;
      start_scan_q <= start_scan_d;
      fifo_din_q   <= fifo_din_d;
      fifo_wr_q    <= fifo_wr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
    end
  end

  assign Out_Chip_Sel   = sel_q;
  assign Out_Chip_ID    = id_q;
  assign Out_Start_Scan = start_scan_q;
  assign Out_Fifo_Din   = fifo_din_q;
  assign Out_Fifo_Wr    = fifo_wr_q;
  assign Out_Busy       = busy_q;
  assign Out_Done       = done_q;
  assign Out_Err_Chip   = err_q;
  assign Out_Overflow   = ovf_q;

endmodule

// File: tb/tb_auto_scan_chip_sequencer.sv
// Directed bench for auto_scan_chip_sequencer with a small scan-engine model and a FIFO-write log.
module tb_auto_scan_chip_sequencer;
  localparam int CN     = 4;
  localparam int SETTLE = 16;
  localparam int TMO    = 1000;

  logic          clk, rst_n, in_start, in_stop, in_fin, in_swr, in_full;
  logic [CN-1:0] in_en;
  logic [15:0]   in_sdin;
  logic [CN-1:0] out_sel, out_err;
  logic [3:0]    out_id;
  logic          out_start, out_wr, out_busy, out_done, out_ovf;
  logic [15:0]   out_din;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  auto_scan_chip_sequencer #(.CHIP_NUM(CN), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
    .Clk_10MHz(clk), .Rst_N(rst_n), .In_Start(in_start), .In_Stop(in_stop),
    .In_Chip_Enable(in_en), .In_Scan_Finish(in_fin), .In_Scan_Fifo_Din(in_sdin),
    .In_Scan_Fifo_Wr(in_swr), .In_Fifo_Full(in_full), .Out_Chip_Sel(out_sel),
    .Out_Chip_ID(out_id), .Out_Start_Scan(out_start), .Out_Fifo_Din(out_din),
    .Out_Fifo_Wr(out_wr), .Out_Busy(out_busy), .Out_Done(out_done),
    .Out_Err_Chip(out_err), .Out_Overflow(out_ovf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Write log: every FIFO word with its cycle stamp, start pulses and done pulses.
  int          cyc = 0, start_cnt = 0, done_cnt = 0;
  logic [15:0] got_q[$];
  int          got_cyc[$];
  int          start_cyc_q[$];
  logic [15:0] exp_q[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (out_wr) begin got_q.push_back(out_din); got_cyc.push_back(cyc); end
    if (out_start) begin start_cnt++; start_cyc_q.push_back(cyc); end
    if (out_done) done_cnt++;
  end

  // Scan engine model: words D0c0/D0c1 at 5/6 cycles after start, finish edge after eng_lat cycles (0 = never).
  int       eng_lat[CN];
  int       ecnt;
  bit       eact;
  logic [3:0] echip;
  initial begin
    in_fin = 0; in_swr = 0; in_sdin = '0; eact = 0; ecnt = 0; echip = '0;
    forever begin
      @(negedge clk);
      if (out_start) begin
        eact = 1; ecnt = 0; echip = out_id; in_swr = 0;
      end else if (eact) begin
        ecnt++;
        in_swr  = (ecnt == 5 || ecnt == 6);
        in_sdin = 16'hD000 | {8'h00, echip, 4'h0} | 16'(ecnt - 5);
        if (eng_lat[echip] != 0 && ecnt == eng_lat[echip]) in_fin = 1;
        if (ecnt == eng_lat[echip] + 3) in_fin = 0;
      end
    end
  end

  task automatic clr();
    @(posedge clk);
    got_q.delete(); got_cyc.delete(); start_cyc_q.delete(); exp_q.delete();
    start_cnt = 0; done_cnt = 0;
  endtask

  task automatic push_chip(input logic [3:0] c, input logic [3:0] st);
    exp_q.push_back({8'hA5, 4'h0, c});
    exp_q.push_back(16'hD000 | {8'h00, c, 4'h0});
    exp_q.push_back(16'hD001 | {8'h00, c, 4'h0});
    exp_q.push_back({8'h5A, st, c});
  endtask

  task automatic kick(input logic [CN-1:0] e);
    @(negedge clk); in_en = e; in_start = 1;
    @(negedge clk); in_start = 0;
  endtask

  task automatic wait_done(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin ok = 1; break; end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (out_start) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    #2;
    chk_cnt++; if (out_sel !== 0 || out_id !== 0) $display("FAIL reset_sel: sel %b id %0d want 0", out_sel, out_id); else pass_cnt++;
    chk_cnt++; if (out_busy !== 0 || out_done !== 0) $display("FAIL reset_busy: busy %b done %b want 0", out_busy, out_done); else pass_cnt++;
    chk_cnt++; if (out_wr !== 0 || out_din !== 0 || out_start !== 0) $display("FAIL reset_wr: wr %b din %h start %b want 0", out_wr, out_din, out_start); else pass_cnt++;
    chk_cnt++; if (out_err !== 0 || out_ovf !== 0) $display("FAIL reset_err: err %b ovf %b want 0", out_err, out_ovf); else pass_cnt++;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_full_run();
    int n; bit ok;
    clr();
    for (int c = 0; c < CN; c++) push_chip(4'(c), 4'h0);
    @(negedge clk); in_en = 4'b1111; in_start = 1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1; n++;
      if (out_start) break;
    end
    chk_cnt++; if (n !== SETTLE + 3) $display("FAIL full_latency: got %0d want %0d", n, SETTLE + 3); else pass_cnt++;
    chk_cnt++; if (out_sel !== 4'b0001 || out_id !== 0) $display("FAIL full_sel: sel %b id %0d want 0001/0", out_sel, out_id); else pass_cnt++;
    // A second start edge while busy must be ignored.
    @(negedge clk); in_start = 0;
    @(negedge clk); in_start = 1;
    @(negedge clk); in_start = 0;
    wait_done(5000, ok);
    chk_cnt++; if (!ok) $display("FAIL full_done_timeout: no done seen"); else pass_cnt++;
    chk_cnt++; if (start_cnt !== 4 || done_cnt !== 1) $display("FAIL full_pulses: starts %0d dones %0d want 4/1", start_cnt, done_cnt); else pass_cnt++;
    chk_cnt++; if (out_err !== 0 || out_busy !== 0 || out_sel !== 0) $display("FAIL full_end: err %b busy %b sel %b want 0", out_err, out_busy, out_sel); else pass_cnt++;
    chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL full_count: got %0d words want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    foreach (exp_q[i]) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL full_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_sparse();
    bit ok;
    clr();
    push_chip(4'd1, 4'h0); push_chip(4'd3, 4'h0);
    kick(4'b1010);
    wait_done(3000, ok);
    chk_cnt++; if (!ok || start_cnt !== 2) $display("FAIL sparse_starts: done %b starts %0d want 1/2", ok, start_cnt); else pass_cnt++;
    chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL sparse_count: got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    foreach (exp_q[i]) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL sparse_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clr();
    eng_lat[2] = 0;
    push_chip(4'd0, 4'h0); push_chip(4'd1, 4'h0); push_chip(4'd2, 4'hE); push_chip(4'd3, 4'h0);
    kick(4'b1111);
    wait_done(8000, ok);
    chk_cnt++; if (!ok || out_err !== 4'b0100) $display("FAIL tmo_err: done %b err %b want 1/0100", ok, out_err); else pass_cnt++;
    chk_cnt++; if (start_cnt !== 4) $display("FAIL tmo_starts: got %0d want 4", start_cnt); else pass_cnt++;
    foreach (exp_q[i]) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL tmo_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]); else pass_cnt++;
    end
    // TMO wait cycles after the Start cycle, then drain, trailer, registered write.
    chk_cnt++;
    if (got_cyc.size() < 12 || start_cyc_q.size() < 3) $display("FAIL tmo_timing: too few events (%0d words)", got_cyc.size());
    else if (got_cyc[11] - start_cyc_q[2] !== TMO + 3) $display("FAIL tmo_timing: got %0d want %0d", got_cyc[11] - start_cyc_q[2], TMO + 3);
    else pass_cnt++;
    eng_lat[2] = 200;
  endtask

  task automatic test_abort_wait();
    bit ok;
    clr();
    eng_lat[1] = 0;
    push_chip(4'd0, 4'h0); push_chip(4'd1, 4'hC);
    kick(4'b1111);
    for (int i = 0; i < 2000 && start_cnt < 2; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    in_stop = 1;
    wait_done(100, ok);
    in_stop = 0;
    chk_cnt++; if (!ok || done_cnt !== 1 || start_cnt !== 2) $display("FAIL abort_pulses: done %0d starts %0d want 1/2", done_cnt, start_cnt); else pass_cnt++;
    chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL abort_count: got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    foreach (exp_q[i]) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL abort_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]); else pass_cnt++;
    end
    eng_lat[1] = 200;
  endtask

  task automatic test_abort_select();
    bit ok;
    clr();
    kick(4'b1111);
    repeat (3) @(negedge clk);
    in_stop = 1;
    @(negedge clk); in_stop = 0;
    wait_done(100, ok);
    chk_cnt++; if (!ok || got_q.size() != 0 || start_cnt !== 0) $display("FAIL stop_select: done %b words %0d starts %0d want 1/0/0", ok, got_q.size(), start_cnt); else pass_cnt++;
    chk_cnt++; if (out_sel !== 0 || out_busy !== 0) $display("FAIL stop_select_idle: sel %b busy %b want 0", out_sel, out_busy); else pass_cnt++;
  endtask

  task automatic test_full_header();
    int n; bit ok;
    clr();
    push_chip(4'd0, 4'h0);
    @(negedge clk); in_en = 4'b0001; in_start = 1; in_full = 1;
    n = 0;
    fork
      begin repeat (SETTLE + 52) @(negedge clk); in_full = 0; end
      begin
        for (int i = 0; i < 200; i++) begin
          @(posedge clk); #1; n++;
          if (out_start) break;
        end
      end
    join
    in_start = 0;
    chk_cnt++; if (n !== SETTLE + 53) $display("FAIL hdr_stall_latency: got %0d want %0d", n, SETTLE + 53); else pass_cnt++;
    wait_done(1000, ok);
    chk_cnt++; if (!ok || got_q.size() != exp_q.size()) $display("FAIL hdr_stall_count: done %b words %0d want %0d", ok, got_q.size(), exp_q.size()); else pass_cnt++;
    foreach (exp_q[i]) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL hdr_stall_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    bit ok;
    clr();
    exp_q.push_back(16'hA500); exp_q.push_back(16'hD001); exp_q.push_back(16'h5A00);
    kick(4'b0001);
    wait_start(ok);
    repeat (6) @(negedge clk);
    in_full = 1;
    @(negedge clk); in_full = 0;
    @(negedge clk);
    chk_cnt++; if (!ok || out_ovf !== 1) $display("FAIL ovf_set: ovf %b want 1", out_ovf); else pass_cnt++;
    wait_done(1000, ok);
    chk_cnt++; if (!ok || out_ovf !== 1) $display("FAIL ovf_sticky: ovf %b want 1", out_ovf); else pass_cnt++;
    chk_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    foreach (exp_q[i]) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL ovf_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_zero_enable();
    int n;
    clr();
    @(negedge clk); in_en = 4'b0000; in_start = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; n++;
      if (out_done) break;
    end
    @(negedge clk); in_start = 0;
    repeat (3) @(negedge clk);
    chk_cnt++; if (n !== 3) $display("FAIL zero_done_latency: got %0d want 3", n); else pass_cnt++;
    chk_cnt++; if (got_q.size() != 0 || start_cnt !== 0) $display("FAIL zero_writes: words %0d starts %0d want 0/0", got_q.size(), start_cnt); else pass_cnt++;
    chk_cnt++; if (out_ovf !== 0 || out_busy !== 0) $display("FAIL zero_clear: ovf %b busy %b want 0/0", out_ovf, out_busy); else pass_cnt++;
  endtask

  task automatic test_stop_finish();
    bit ok;
    clr();
    eng_lat[0] = 30;
    push_chip(4'd0, 4'hC);
    kick(4'b0001);
    wait_start(ok);
    repeat (31) @(negedge clk);
    in_stop = 1;
    wait_done(100, ok);
    in_stop = 0;
    chk_cnt++; if (!ok || got_q.size() != exp_q.size()) $display("FAIL stopfin_count: done %b words %0d want %0d", ok, got_q.size(), exp_q.size()); else pass_cnt++;
    foreach (exp_q[i]) begin
      chk_cnt++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) $display("FAIL stopfin_word%0d: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 16'hxxxx, exp_q[i]); else pass_cnt++;
    end
    eng_lat[0] = 200;
  endtask

  task automatic test_reset_mid();
    bit ok;
    clr();
    kick(4'b1111);
    wait_start(ok);
    repeat (10) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk_cnt++; if (!ok || out_sel !== 0 || out_id !== 0 || out_busy !== 0) $display("FAIL rstmid_sel: sel %b id %0d busy %b want 0", out_sel, out_id, out_busy); else pass_cnt++;
    chk_cnt++; if (out_wr !== 0 || out_din !== 0 || out_start !== 0 || out_done !== 0) $display("FAIL rstmid_wr: wr %b din %h start %b done %b want 0", out_wr, out_din, out_start, out_done); else pass_cnt++;
    @(negedge clk); rst_n = 1;
    clr();
    repeat (300) @(negedge clk);
    chk_cnt++; if (got_q.size() != 0 || out_busy !== 0) $display("FAIL rstmid_quiet: words %0d busy %b want 0/0", got_q.size(), out_busy); else pass_cnt++;
  endtask

  initial begin
    rst_n = 0; in_start = 0; in_stop = 0; in_full = 0; in_en = '0;
    for (int c = 0; c < CN; c++) eng_lat[c] = 200;
    repeat (2) @(negedge clk);
    test_reset();
    repeat (3) @(negedge clk);
    test_full_run();
    test_sparse();
    test_timeout();
    test_abort_wait();
    test_abort_select();
    test_full_header();
    test_overflow();
    test_zero_enable();
    test_stop_finish();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
